// File: rtl/hpdmc_wrdqs_pkg.sv
// hpdmc_wrdqs_pkg: shared states, pad-control levels and counter sizing (HPDMC_WR_POSTAMBLE_EXT_EN adds POST2)
package hpdmc_wrdqs_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PRE,
    BURST,
`ifdef HPDMC_WR_POSTAMBLE_EXT_EN
    POST,
    POST2
`else
    POST
`endif
  } state_t;
  localparam logic T_HIZ = 1'b1;
  localparam logic T_DRIVE = 1'b0;
  function automatic int cnt_w(input int burst_cycles);
    return $clog2(burst_cycles + 2);
  endfunction
endpackage

// File: rtl/hpdmc_delay_line.sv
// hpdmc_delay_line: WL-stage shift register turning write_start into go
module hpdmc_delay_line #(
  parameter int WL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fill
);
  logic [WL-1:0] sr, sr_n;
  assign sr_n = (sr << 1) | WL'(d);
  assign q = sr[WL-1];
  assign fill = |sr_n;
  always_ff @(posedge clk)
    sr <= rst ? '0 : sr_n;
endmodule

// File: rtl/hpdmc_wrdqs_ctl.sv
// hpdmc_wrdqs_ctl: write-side DQS/DM/DQ tristate sequencer (HPDMC_WR_POSTAMBLE_EXT_EN: two-cycle postamble)
module hpdmc_wrdqs_ctl
  import hpdmc_wrdqs_pkg::*;
#(
  parameter int WL = 2,
  parameter int BURST_CYCLES = 4,
  parameter int NBYTES = 2
) (
  input  logic              sys_clk,
  input  logic              sdram_rst,
  input  logic              write_start,
  output logic [NBYTES-1:0] dqs_t,
  output logic [NBYTES-1:0] dm_t,
  output logic [NBYTES-1:0] dq_t,
  output logic              wdata_req,
  output logic              burst_last,
  output logic              busy,
  output logic              overlap_err
);
  localparam int CW = cnt_w(BURST_CYCLES);
  logic go, fill, bad;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  hpdmc_delay_line #(.WL(WL)) u_dl (
    .clk(sys_clk),
    .rst(sdram_rst),
    .d(write_start),
    .q(go),
    .fill(fill)
  );
  // A go landing with two burst cycles left extends the burst seamlessly
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bad = 1'b0;
    case (state)
      IDLE: state_n = go ? PRE : IDLE;
      PRE: begin
        state_n = BURST;
        cnt_n = CW'(BURST_CYCLES);
        bad = go;
      end
      BURST: begin
        if (go && cnt == CW'(2)) cnt_n = CW'(BURST_CYCLES + 1);
        else begin
          bad = go;
          cnt_n = cnt - CW'(1);
          state_n = cnt == CW'(1) ? POST : BURST;
        end
      end
`ifdef HPDMC_WR_POSTAMBLE_EXT_EN
      POST: state_n = go ? PRE : POST2;
      POST2: state_n = go ? PRE : IDLE;
`else
      POST: state_n = go ? PRE : IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state <= IDLE;
      cnt <= '0;
      dqs_t <= {NBYTES{T_HIZ}};
      dm_t <= {NBYTES{T_HIZ}};
      dq_t <= {NBYTES{T_HIZ}};
      wdata_req <= 1'b0;
      burst_last <= 1'b0;
      busy <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dqs_t <= {NBYTES{state_n == IDLE ? T_HIZ : T_DRIVE}};
      dm_t <= {NBYTES{state_n == BURST ? T_DRIVE : T_HIZ}};
      dq_t <= {NBYTES{state_n == BURST ? T_DRIVE : T_HIZ}};
      wdata_req <= state_n == BURST;
      burst_last <= state_n == BURST && cnt_n == CW'(1);
      busy <= state_n != IDLE || fill;
      overlap_err <= overlap_err | bad;
    end
  end
endmodule

// File: tb/tb_hpdmc_wrdqs_ctl.sv
// tb_hpdmc_wrdqs_ctl: vector table, directed sequences and random writes against a timeline model
module tb_hpdmc_wrdqs_ctl;
  localparam int WL = 2;
  localparam int BC = 4;
  localparam int NB = 2;
`ifdef HPDMC_WR_POSTAMBLE_EXT_EN
  localparam int PE = 2;
`else
  localparam int PE = 1;
`endif
  typedef struct {
    logic ws, rst, dqs, dq, wreq, blast, busy, err;
  } vec_t;
  logic sys_clk = 1'b0, sdram_rst = 1'b1, write_start = 1'b0;
  logic [NB-1:0] dqs_t, dm_t, dq_t;
  logic wdata_req, burst_last, busy, overlap_err;
  int n_chk = 0, n_fail = 0, cyc = 0, last_rst = -1, p = 0, be = 0, n_req = 0, n_last = 0;
  bit have = 0, err = 0;
  bit hist [0:8191];
  vec_t tab [$];
  hpdmc_wrdqs_ctl #(.WL(WL), .BURST_CYCLES(BC), .NBYTES(NB)) dut (
    .sys_clk(sys_clk),
    .sdram_rst(sdram_rst),
    .write_start(write_start),
    .dqs_t(dqs_t),
    .dm_t(dm_t),
    .dq_t(dq_t),
    .wdata_req(wdata_req),
    .burst_last(burst_last),
    .busy(busy),
    .overlap_err(overlap_err)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask
  function automatic bit wr_at(input int t);
    if (t < 0 || t <= last_rst) return 1'b0;
    return hist[t];
  endfunction
  function automatic vec_t mk(input logic ws, rst, dqs, dq, wreq, blast, bsy, e);
    vec_t v;
    v.ws = ws; v.rst = rst; v.dqs = dqs; v.dq = dq;
    v.wreq = wreq; v.blast = blast; v.busy = bsy; v.err = e;
    return v;
  endfunction
  // Model: a go opens a window PRE at p, burst up to be, postamble after be
  task automatic step(input vec_t v, input bit use_tab);
    bit pre, bu, po, eb;
    write_start = v.ws;
    sdram_rst = v.rst;
    hist[cyc] = v.ws;
    @(negedge sys_clk);
    pre = have && cyc == p;
    bu = have && cyc > p && cyc <= be;
    po = have && cyc > be && cyc <= be + PE;
    eb = pre | bu | po;
    for (int k = 1; k <= WL; k++) if (wr_at(cyc - k)) eb = 1'b1;
    chk("dqs_t", dqs_t, {NB{!(pre | bu | po)}});
    chk("dm_t", dm_t, {NB{!bu}});
    chk("dq_t", dq_t, {NB{!bu}});
    chk("wdata_req", wdata_req, bu);
    chk("burst_last", burst_last, bu && cyc == be);
    chk("busy", busy, eb);
    chk("overlap_err", overlap_err, err);
    if (use_tab) begin
      chk("tab_dqs_t", dqs_t, {NB{v.dqs}});
      chk("tab_dq_t", dq_t, {NB{v.dq}});
      chk("tab_wdata_req", wdata_req, v.wreq);
      chk("tab_burst_last", burst_last, v.blast);
      chk("tab_busy", busy, v.busy);
      chk("tab_overlap_err", overlap_err, v.err);
    end
    n_req += int'(wdata_req);
    n_last += int'(burst_last);
    if (v.rst) begin
      have = 0;
      err = 0;
      last_rst = cyc;
    end else if (wr_at(cyc - WL)) begin
      if (!have || cyc > be) begin
        have = 1;
        p = cyc + 1;
        be = cyc + 1 + BC;
      end else if (cyc == be - 1) be += BC;
      else err = 1;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask
  task automatic pair(input int a, input int b, input int len);
    n_req = 0;
    n_last = 0;
    for (int i = 0; i < len; i++) step(mk(i == a || i == b, 0, 0, 0, 0, 0, 0, 0), 0);
  endtask
  initial begin
    int nxt, g;
    int gaps [9] = '{1, 2, 3, BC, BC, BC, BC + 1, BC + 5, 12};
    tab.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, PE == 1, 1, 0, 0, PE == 2, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
    repeat (3) @(posedge sys_clk);
    #1;
    sdram_rst = 1'b0;
    foreach (tab[i]) step(tab[i], 1);
    pair(0, BC, 20);
    chk("b2b_last", n_last, 1);
    chk("b2b_req", n_req, 2 * BC);
    chk("b2b_err", overlap_err, 0);
    pair(0, 9, 22);
    chk("gap_last", n_last, 2);
    chk("gap_req", n_req, 2 * BC);
    pair(0, 6, 20);
    chk("post_go_last", n_last, 2);
    chk("post_go_err", overlap_err, 0);
    pair(0, 2, 14);
    chk("close_req", n_req, BC);
    chk("close_err", overlap_err, 1);
    step(mk(0, 1, 0, 0, 0, 0, 0, 0), 0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    chk("rst_clears_err", overlap_err, 0);
    nxt = 0;
    for (int i = 0; i < 3000; i++) begin
      g = int'($urandom_range(0, 8));
      step(mk(nxt == 0, $urandom_range(0, 299) == 0, 0, 0, 0, 0, 0, 0), 0);
      nxt = (nxt == 0) ? gaps[g] - 1 : nxt - 1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
